// File: rtl/negate_arbiter.sv
// Round-robin arbiter sharing one bit-serial two's-complement engine among four requesters.
// Requests needing negation go through the engine; all others are answered by bypass.
module negate_arbiter #(
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [7:0]      req_op,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      grant,
    output logic            eng_start,
    output logic [DW-1:0]   eng_din,
    output logic            eng_reset,
    input  logic            eng_done,
    input  logic [DW-1:0]   eng_dout,
    output logic            resp_valid,
    output logic [1:0]      resp_id,
    output logic [DW-1:0]   resp_data,
    output logic            resp_err,
    output logic            busy
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      id_q, id_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic            win_found;
    logic [1:0]      win;
    logic [1:0]      cand;
    logic [1:0]      win_op;
    logic [DW-1:0]   win_data;
    logic            needs_neg;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win       = ptr_q;
        cand      = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    assign win_op    = req_op[2*win +: 2];
    assign win_data  = req_data[DW*win +: DW];
    assign needs_neg = (win_op == 2'b01) || ((win_op == 2'b10) && win_data[DW-1]);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        data_d      = data_q;
        grant_d     = 4'b0000;
        cnt_d       = cnt_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    ptr_d   = win;
                    id_d    = win;
                    data_d  = win_data;
                    grant_d = 4'b0001 << win;
                    if (needs_neg) begin
                        state_d = StIssue;
                    end else begin
                        state_d     = StResp;
                        resp_id_d   = win;
                        resp_data_d = win_data;
                        resp_err_d  = 1'b0;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last watchdog cycle still wins.
                if (eng_done) begin
                    state_d     = StResp;
                    resp_id_d   = id_q;
                    resp_data_d = eng_dout;
                    resp_err_d  = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = StResp;
                    resp_id_d   = id_q;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd3;
            id_q        <= '0;
            data_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign grant      = grant_q;
    assign eng_start  = (state_q == StIssue);
    assign eng_din    = data_q;
    assign eng_reset  = reset || (state_q == StResp);
    assign resp_valid = (state_q == StResp);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_negate_arbiter.sv
// Bench for negate_arbiter: cycle-scheduled transaction model, a 17-cycle engine stub and
// directed transactions with literal expectations.
module tb_negate_arbiter;

    localparam int DW      = 16;
    localparam int TIMEOUT = 32;
    localparam int LAT     = 17;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [7:0]      req_op;
    logic [4*DW-1:0] req_data;
    logic [3:0]      grant;
    logic            eng_start;
    logic [DW-1:0]   eng_din;
    logic            eng_reset;
    logic            eng_done;
    logic [DW-1:0]   eng_dout;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic            busy;

    always #5 clk = ~clk;

    negate_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_op     (req_op),
        .req_data   (req_data),
        .grant      (grant),
        .eng_start  (eng_start),
        .eng_din    (eng_din),
        .eng_reset  (eng_reset),
        .eng_done   (eng_done),
        .eng_dout   (eng_dout),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // Written by the compare process only.
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    bit m_active;
    int m_ptr, m_win, g_at, s_at, w_from, r_at;
    logic [1:0]    opv;
    logic [DW-1:0] dv;
    logic [3:0]    e_grant;
    logic          e_start, e_valid, e_err, e_busy;
    logic [1:0]    e_id;
    logic [DW-1:0] e_data, e_din;
    int last_grant_cyc, starts, pin_ack, pin_seen, pin_deadline, ord_seen, ord_idx, gidx;

    // Written by the stimulus process only.
    int pin_seq = 0;
    int pin_id, pin_lat, pin_starts;
    logic [DW-1:0] pin_data;
    logic          pin_err;
    int ord_seq = 0;
    int ord_len = 0;
    int ord_exp[5];
    int rerun[4];
    int inj_req = 0;
    bit eng_mode;

    // Written by the engine process only.
    int inj_ack = 0;
    logic [DW-1:0] eng_v;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", 32'(grant), 32'(e_grant));
            chk("eng_start", 32'(eng_start), 32'(e_start));
            chk("eng_din", 32'(eng_din), 32'(e_din));
            chk("eng_reset", 32'(eng_reset), 32'(e_valid | reset));
            chk("resp_valid", 32'(resp_valid), 32'(e_valid));
            chk("resp_id", 32'(resp_id), 32'(e_id));
            chk("resp_data", 32'(resp_data), 32'(e_data));
            chk("resp_err", 32'(resp_err), 32'(e_err));
            chk("busy", 32'(busy), 32'(e_busy));

            if (ord_seq != ord_seen) begin
                ord_seen = ord_seq;
                ord_idx  = 0;
            end
            if (grant != 4'b0000) begin
                last_grant_cyc = cyc;
                starts = 0;
                gidx = 0;
                for (int i = 0; i < 4; i++) if (grant[i]) gidx = i;
                if (ord_idx < ord_len) begin
                    chk("grant_order", 32'(gidx), 32'(ord_exp[ord_idx]));
                    ord_idx++;
                end
            end
            if (eng_start) starts++;

            if (pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                pin_deadline = cyc + 80;
            end
            if (pin_ack != pin_seq) begin
                if (resp_valid) begin
                    chk("pin_id", 32'(resp_id), 32'(pin_id));
                    chk("pin_data", 32'(resp_data), 32'(pin_data));
                    chk("pin_err", 32'(resp_err), 32'(pin_err));
                    chk("pin_latency", 32'(cyc - last_grant_cyc), 32'(pin_lat));
                    chk("pin_starts", 32'(starts), 32'(pin_starts));
                    pin_ack = pin_seq;
                end else if (cyc > pin_deadline) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pin_wait: got no response expected one by cycle %0d", cyc);
                    pin_ack = pin_seq;
                end
            end
        end

        // Model: schedule grant/start/response as absolute cycle numbers.
        if (reset) begin
            m_active = 1'b0;
            m_ptr = 3;
            m_win = 0;
            g_at = -1;
            s_at = -1;
            r_at = -1;
            w_from = -1;
            e_id = '0;
            e_data = '0;
            e_err = 1'b0;
            e_din = '0;
            chk_en = 1'b1;
        end else if (m_active) begin
            if (cyc == r_at) begin
                m_active = 1'b0;
            end else if (r_at < 0 && cyc >= w_from) begin
                if (eng_done) begin
                    r_at = cyc + 1;
                    e_id = 2'(m_win);
                    e_data = eng_dout;
                    e_err = 1'b0;
                end else if (cyc == w_from + TIMEOUT - 1) begin
                    r_at = cyc + 1;
                    e_id = 2'(m_win);
                    e_data = '0;
                    e_err = 1'b1;
                end
            end
        end else if (req != 4'b0000) begin
            m_win = -1;
            for (int k = 1; k <= 4; k++) begin
                if (m_win < 0 && req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
            end
            m_ptr = m_win;
            opv = req_op[2*m_win +: 2];
            dv = req_data[DW*m_win +: DW];
            e_din = dv;
            g_at = cyc + 1;
            m_active = 1'b1;
            if (opv == 2'b01 || (opv == 2'b10 && dv[DW-1])) begin
                s_at = cyc + 1;
                w_from = cyc + 2;
                r_at = -1;
            end else begin
                s_at = -1;
                r_at = cyc + 1;
                e_id = 2'(m_win);
                e_data = dv;
                e_err = 1'b0;
            end
        end
        e_grant = (cyc + 1 == g_at) ? 4'(1 << m_win) : 4'd0;
        e_start = (cyc + 1 == s_at);
        e_valid = (cyc + 1 == r_at);
        e_busy  = m_active;
        cyc++;
    end

    // Engine stub: negates the operand LAT cycles after start, or stays silent when disabled.
    initial begin
        eng_done = 1'b0;
        eng_dout = '0;
        forever begin
            @(negedge clk);
            if (inj_ack != inj_req) begin
                inj_ack = inj_req;
                @(posedge clk);
                #1 eng_done = 1'b1;
                eng_dout = 16'hDEAD;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end else if (eng_start && eng_mode) begin
                eng_v = -eng_din;
                repeat (LAT) @(posedge clk);
                #1 eng_done = 1'b1;
                eng_dout = eng_v;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) req[i] = 1'b0;
            if (resp_valid && resp_id == 2'(i) && rerun[i] > 0) begin
                req[i] = 1'b1;
                rerun[i]--;
            end
        end
    endtask

    task automatic raise(input int i, input logic [1:0] op, input logic [DW-1:0] d);
        req_op[2*i +: 2] = op;
        req_data[DW*i +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic transact(input int i, input logic [1:0] op, input logic [DW-1:0] d,
                            input logic [DW-1:0] xd, input logic xe, input int lat,
                            input int st);
        pin_id = i;
        pin_data = xd;
        pin_err = xe;
        pin_lat = lat;
        pin_starts = st;
        pin_seq++;
        raise(i, op, d);
        for (int t = 0; t < 100 && pin_ack != pin_seq; t++) step();
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_op = '0;
        req_data = '0;
        eng_mode = 1'b1;
        for (int i = 0; i < 4; i++) rerun[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Fairness with all four requesting, requester 0 re-raising once.
        ord_exp = '{0, 1, 2, 3, 0};
        ord_len = 5;
        ord_seq++;
        rerun[0] = 1;
        for (int i = 0; i < 4; i++) raise(i, 2'b00, 16'(16'h1000 + i));
        repeat (16) step();

        ord_exp[0] = 1;
        ord_exp[1] = 3;
        ord_exp[2] = 1;
        ord_len = 3;
        ord_seq++;
        rerun[1] = 1;
        raise(1, 2'b00, 16'h2111);
        raise(3, 2'b00, 16'h2333);
        repeat (12) step();
        ord_len = 0;
        ord_seq++;

        // Bypass paths.
        transact(2, 2'b00, 16'h1234, 16'h1234, 1'b0, 0, 0);
        transact(2, 2'b10, 16'h0005, 16'h0005, 1'b0, 0, 0);
        transact(3, 2'b11, 16'hBEEF, 16'hBEEF, 1'b0, 0, 0);

        // Engine paths: grant -> response is LAT + 1 cycles.
        transact(1, 2'b01, 16'h0003, 16'hFFFD, 1'b0, 18, 1);
        transact(0, 2'b10, 16'hFFFB, 16'h0005, 1'b0, 18, 1);

        // Watchdog expiry, then a stray done while idle.
        eng_mode = 1'b0;
        transact(0, 2'b01, 16'h0005, 16'h0000, 1'b1, 33, 1);
        eng_mode = 1'b1;
        inj_req++;
        repeat (5) step();

        // Reset while waiting on the engine; its late done must be ignored.
        raise(1, 2'b01, 16'h0042);
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (25) step();

        transact(2, 2'b01, 16'h8000, 16'h8000, 1'b0, 18, 1);
        transact(0, 2'b10, 16'h8000, 16'h8000, 1'b0, 18, 1);
        transact(3, 2'b00, 16'h7FFF, 16'h7FFF, 1'b0, 0, 0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
